// File: rtl/text_streamer_pkg.sv
// text_streamer_pkg: shared state encoding, character constants and a helper
// that packs a string literal into the streamer's TEXT layout.
package text_streamer_pkg;
    typedef enum logic {IDLE, RUN} state_t;
    localparam int CHAR_W_DEF = 8;
    localparam int PACK_MAX = 32;
    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] NUL = 8'h00;

    // A literal is right-justified, so its first character sits highest; char 0 must land in the LSBs.
    function automatic logic [PACK_MAX*8-1:0] pack_text(input logic [PACK_MAX*8-1:0] s, input int n);
        logic [PACK_MAX*8-1:0] r;
        for (int i = 0; i < PACK_MAX; i++) begin
            if (i < n) r[i*8 +: 8] = s[(n-1-i)*8 +: 8];
            else r[i*8 +: 8] = SPACE;
        end
        return r;
    endfunction
endpackage

// File: rtl/text_streamer_tick_div.sv
// tick_div: reloadable down-counter; tick is high while the count is zero.
module tick_div
    import text_streamer_pkg::*;
#(
    parameter int DIV_W = 16
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] reload,
    output logic             tick
);
    logic [DIV_W-1:0] r_cnt;

    assign tick = (r_cnt == '0);

    always_ff @(posedge clk or posedge rst)
        if (rst) r_cnt <= '0;
        else if (en) r_cnt <= clr ? '0 : tick ? reload : r_cnt - 1'b1;
endmodule

// File: rtl/text_streamer.sv
// text_streamer: emits a ROM string one character per rate_div+1 enabled
// cycles, one-shot or looping, with registered strobe/index/done outputs.
module text_streamer
    import text_streamer_pkg::*;
#(
    parameter int CHAR_W = CHAR_W_DEF,
    parameter int DEPTH = 32,
    parameter int LEN = 32,
    parameter logic [DEPTH*CHAR_W-1:0] TEXT = {DEPTH{CHAR_W'(SPACE)}},
    parameter int DIV_W = 16,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_mode,
    input  logic [DIV_W-1:0]  rate_div,
    output logic [CHAR_W-1:0] char_out,
    output logic              char_valid,
    output logic [IDX_W-1:0]  index,
    output logic              busy,
    output logic              done
);
    if (LEN < 1 || LEN > DEPTH) begin : g_len_chk
        $error("text_streamer: LEN must satisfy 1 <= LEN <= DEPTH");
    end

    localparam logic [IDX_W-1:0] LAST = IDX_W'(LEN - 1);

    state_t            r_state;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_index;
    logic [CHAR_W-1:0] r_char;
    logic              r_valid;
    logic              r_done;
    logic              w_go;
    logic              w_div_en;
    logic              w_tick;

    assign w_go = (r_state == IDLE) && start && !stop;
    // The divider only runs while streaming, and is cleared on the edge that enters RUN.
    assign w_div_en = en && (w_go || (r_state == RUN && !stop));

    tick_div #(.DIV_W(DIV_W)) u_div (
        .clk    (clk),
        .rst    (rst),
        .en     (w_div_en),
        .clr    (w_go),
        .reload (rate_div),
        .tick   (w_tick)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_index <= '0;
            r_char  <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else if (!en) begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            if (r_state == IDLE) begin
                if (w_go) begin
                    r_state <= RUN;
                    r_ptr   <= '0;
                end
            end else if (stop) begin
                r_state <= IDLE;
            end else if (w_tick) begin
                r_char  <= TEXT[r_ptr*CHAR_W +: CHAR_W];
                r_index <= r_ptr;
                r_valid <= 1'b1;
                if (r_ptr != LAST) r_ptr <= r_ptr + 1'b1;
                else if (loop_mode) r_ptr <= '0;
                else begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
            end
        end

    assign char_out   = r_char;
    assign char_valid = r_valid;
    assign index      = r_index;
    assign done       = r_done;
    assign busy       = (r_state == RUN);
endmodule
